// File: rtl/split_pkg.sv
// Shared types and default sizes for the split stream checker.
// Imported by the interface, the bound table and the checker top.
package split_pkg;

    typedef enum logic [1:0] {
        MODE_TAUT,
        MODE_LE,
        MODE_EQ,
        MODE_NE
    } split_mode_e;

    typedef enum logic {
        ST_ACCUM,
        ST_RESULT
    } split_state_e;

    localparam int NUM_VARS_DEF = 150;
    localparam int MAX_W_DEF    = 16;

endpackage

// File: rtl/split_stream_checker_if.sv
// Value stream in / result out handshake bundle for split_stream_checker.
// The master drives beats and consumes results; the slave is the checker.
interface split_stream_checker_if
    import split_pkg::*;
#(
    parameter int NUM_VARS = NUM_VARS_DEF,
    parameter int MAX_W    = MAX_W_DEF
);
    localparam int IDX_W = $clog2(NUM_VARS);

    logic             in_valid;
    logic             in_ready;
    logic [MAX_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sat;
    logic [IDX_W-1:0] out_viol_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sat, out_viol_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sat, out_viol_idx
    );

endinterface

// File: rtl/split_bound_table.sv
// Per-variable bound storage: one write port, one combinational read port.
// Every entry comes out of reset as all-ones so an unprogrammed LE check always passes.
module split_bound_table
    import split_pkg::*;
#(
    parameter int NUM_VARS = NUM_VARS_DEF,
    parameter int MAX_W    = MAX_W_DEF,
    parameter int IDX_W    = $clog2(NUM_VARS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [MAX_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [MAX_W-1:0] rdata_o
);

    logic [MAX_W-1:0] bound_q [NUM_VARS];
    logic             wr_ok;

    // Compared one bit wider so a power-of-two NUM_VARS still rejects out-of-range writes.
    assign wr_ok = we_i && ({1'b0, widx_i} < (IDX_W+1)'(NUM_VARS));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                bound_q[i] <= '1;
            end
        end else if (wr_ok) begin
            bound_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = bound_q[ridx_i];

endmodule

// File: rtl/split_stream_checker.sv
// Sequential constraint-split checker: one variable per beat, one satisfied flag per frame.
// Define SPLIT_VIOL_CAPTURE_EN to report the index of the first failing variable.
module split_stream_checker
    import split_pkg::*;
#(
    parameter int NUM_VARS = NUM_VARS_DEF,
    parameter int MAX_W    = MAX_W_DEF,
    parameter int IDX_W    = $clog2(NUM_VARS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [MAX_W-1:0]     cfg_bound,
    input  logic [1:0]           mode,
    input  logic                 abort,
    split_stream_checker_if.slave strm
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

    split_state_e     state_q;
    split_mode_e      mode_q;
    logic [IDX_W-1:0] idx_q;
    logic             acc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_sat_q;
    logic [MAX_W-1:0] bound_rd;
    split_mode_e      mode_d;
    logic             pass_d;
    logic             acc_d;
`ifdef SPLIT_VIOL_CAPTURE_EN
    logic [IDX_W-1:0] viol_q;
    logic [IDX_W-1:0] out_viol_idx_q;
`endif

    // The table is read before any same-cycle write lands, so a beat sees the old bound.
    split_bound_table #(
        .NUM_VARS (NUM_VARS),
        .MAX_W    (MAX_W),
        .IDX_W    (IDX_W)
    ) u_bounds (
        .clk     (clk),
        .rst     (rst),
        .we_i    (cfg_we),
        .widx_i  (cfg_idx),
        .wdata_i (cfg_bound),
        .ridx_i  (idx_q),
        .rdata_o (bound_rd)
    );

    always_comb begin
        mode_d = (idx_q == '0) ? split_mode_e'(mode) : mode_q;
        pass_d = 1'b1;
        case (mode_d)
            MODE_TAUT: pass_d = 1'b1;
            MODE_LE:   pass_d = (strm.in_data <= bound_rd);
            MODE_EQ:   pass_d = (strm.in_data == bound_rd);
            MODE_NE:   pass_d = (strm.in_data != bound_rd);
            default:   pass_d = 1'b1;
        endcase
        acc_d = acc_q & pass_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            mode_q      <= MODE_TAUT;
            idx_q       <= '0;
            acc_q       <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
`ifdef SPLIT_VIOL_CAPTURE_EN
            viol_q         <= '0;
            out_viol_idx_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (abort) begin
                        idx_q <= '0;
                        acc_q <= 1'b1;
                    end else if (strm.in_valid) begin
                        mode_q <= mode_d;
`ifdef SPLIT_VIOL_CAPTURE_EN
                        if (acc_q && !pass_d) begin
                            viol_q <= idx_q;
                        end
`endif
                        if (idx_q == LAST_IDX) begin
                            state_q     <= ST_RESULT;
                            idx_q       <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_sat_q   <= acc_d;
`ifdef SPLIT_VIOL_CAPTURE_EN
                            // The last beat may itself be the first failure of the frame.
                            out_viol_idx_q <= acc_d ? '0 : (acc_q ? idx_q : viol_q);
`endif
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            acc_q <= acc_d;
                        end
                    end
                end
                ST_RESULT: begin
                    if (strm.out_ready) begin
                        state_q     <= ST_ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        acc_q       <= 1'b1;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_sat   = out_sat_q;
`ifdef SPLIT_VIOL_CAPTURE_EN
    assign strm.out_viol_idx = out_viol_idx_q;
`else
    assign strm.out_viol_idx = '0;
`endif

endmodule

// File: tb/tb_split_stream_checker.sv
// Directed testbench for split_stream_checker with a frame-level reference model.
// Frames are collected as value/bound lists and judged once complete; outputs are compared every cycle.
module tb_split_stream_checker;
    import split_pkg::*;

    localparam int NUM_VARS = NUM_VARS_DEF;
    localparam int MAX_W    = MAX_W_DEF;
    localparam int IDX_W    = $clog2(NUM_VARS);

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [MAX_W-1:0] cfg_bound;
    logic [1:0]       mode;
    logic             abort;

    int vecCount  = 0;
    int missCount = 0;
    bit checkEn   = 1'b0;

    logic [MAX_W-1:0] frameData [NUM_VARS];

    logic [MAX_W-1:0] mBounds [NUM_VARS];
    logic [MAX_W-1:0] mVals [$];
    logic [MAX_W-1:0] mBnds [$];
    split_mode_e      mMode;
    bit               mInResult = 1'b0;
    bit               eSat      = 1'b0;
    logic [IDX_W-1:0] eViol     = '0;

    split_stream_checker_if #(.NUM_VARS(NUM_VARS), .MAX_W(MAX_W)) strm ();

    split_stream_checker #(
        .NUM_VARS (NUM_VARS),
        .MAX_W    (MAX_W),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_bound (cfg_bound),
        .mode      (mode),
        .abort     (abort),
        .strm      (strm.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit modelPass(input split_mode_e m, input logic [MAX_W-1:0] v, input logic [MAX_W-1:0] b);
        case (m)
            MODE_LE: return v <= b;
            MODE_EQ: return v == b;
            MODE_NE: return v != b;
            default: return 1'b1;
        endcase
    endfunction

    // Reference model: gathers each frame's accepted values with the bound seen at acceptance.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mInResult = 1'b0;
                mVals.delete();
                mBnds.delete();
                eSat  = 1'b0;
                eViol = '0;
                foreach (mBounds[i]) mBounds[i] = '1;
            end else begin
                if (!mInResult) begin
                    if (abort) begin
                        mVals.delete();
                        mBnds.delete();
                    end else if (strm.in_valid) begin
                        if (mVals.size() == 0) mMode = split_mode_e'(mode);
                        mBnds.push_back(mBounds[mVals.size()]);
                        mVals.push_back(strm.in_data);
                        if (mVals.size() == NUM_VARS) begin
                            eSat  = 1'b1;
                            eViol = '0;
                            for (int i = 0; i < NUM_VARS; i++) begin
                                if (!modelPass(mMode, mVals[i], mBnds[i])) begin
                                    if (eSat) eViol = IDX_W'(i);
                                    eSat = 1'b0;
                                end
                            end
`ifndef SPLIT_VIOL_CAPTURE_EN
                            eViol = '0;
`endif
                            mInResult = 1'b1;
                            mVals.delete();
                            mBnds.delete();
                        end
                    end
                end else if (strm.out_ready) begin
                    mInResult = 1'b0;
                end
                if (cfg_we && int'(cfg_idx) < NUM_VARS) mBounds[cfg_idx] = cfg_bound;
            end
        end
    end

    // Per-cycle comparison of the handshake and result against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                checkOutput("in_ready", 32'(strm.in_ready), 32'(!mInResult));
                checkOutput("out_valid", 32'(strm.out_valid), 32'(mInResult));
                if (mInResult) begin
                    checkOutput("out_sat", 32'(strm.out_sat), 32'(eSat));
                    checkOutput("out_viol_idx", 32'(strm.out_viol_idx), 32'(eViol));
                end
            end
        end
    end

    // Drives one cycle of inputs and returns at the following negedge.
    task automatic applyStimulus(input bit valid, input logic [MAX_W-1:0] data, input split_mode_e modeV,
                                 input bit abortV, input bit outReady);
        strm.in_valid  = valid;
        strm.in_data   = data;
        mode           = modeV;
        abort          = abortV;
        strm.out_ready = outReady;
        @(negedge clk);
    endtask

    task automatic writeBound(input int idx, input logic [MAX_W-1:0] val);
        cfg_we    = 1'b1;
        cfg_idx   = IDX_W'(idx);
        cfg_bound = val;
        applyStimulus(1'b0, '0, MODE_TAUT, 1'b0, 1'b0);
        cfg_we    = 1'b0;
    endtask

    task automatic sendFrame(input split_mode_e firstMode, input split_mode_e laterMode, input int gapEvery,
                             input int writeAt, input logic [MAX_W-1:0] writeVal,
                             input bit expSat, input int expViol, input string tag);
        int viol;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (gapEvery > 0 && (i % gapEvery) == 1) begin
                applyStimulus(1'b0, 16'hDEAD, laterMode, 1'b0, 1'b0);
            end
            if (i == writeAt) begin
                cfg_we    = 1'b1;
                cfg_idx   = IDX_W'(i);
                cfg_bound = writeVal;
            end
            applyStimulus(1'b1, frameData[i], (i == 0) ? firstMode : laterMode, 1'b0, 1'b0);
            cfg_we = 1'b0;
        end
        strm.in_valid = 1'b0;
`ifdef SPLIT_VIOL_CAPTURE_EN
        viol = expSat ? 0 : expViol;
`else
        viol = 0;
`endif
        checkOutput({tag, "_latency_valid"}, 32'(strm.out_valid), 32'd1);
        checkOutput({tag, "_in_ready_low"}, 32'(strm.in_ready), 32'd0);
        checkOutput({tag, "_sat"}, 32'(strm.out_sat), 32'(expSat));
        checkOutput({tag, "_viol"}, 32'(strm.out_viol_idx), 32'(viol));
    endtask

    task automatic consumeResult(input string tag);
        applyStimulus(1'b0, '0, MODE_TAUT, 1'b0, 1'b1);
        strm.out_ready = 1'b0;
        checkOutput({tag, "_ready_after_consume"}, 32'(strm.in_ready), 32'd1);
        checkOutput({tag, "_valid_after_consume"}, 32'(strm.out_valid), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        cfg_we         = 1'b0;
        cfg_idx        = '0;
        cfg_bound      = '0;
        mode           = MODE_TAUT;
        abort          = 1'b0;
        strm.in_valid  = 1'b0;
        strm.in_data   = '0;
        strm.out_ready = 1'b0;
        applyStimulus(1'b0, '0, MODE_TAUT, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, MODE_TAUT, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(strm.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(strm.out_valid), 32'd0);
        checkOutput("reset_out_sat", 32'(strm.out_sat), 32'd0);
        checkOutput("reset_viol", 32'(strm.out_viol_idx), 32'd0);
        checkEn = 1'b1;

        writeBound(NUM_VARS, 16'h0000);

        // TAUT frame, later beats show EQ to prove the mode is latched at index 0.
        for (int i = 0; i < NUM_VARS; i++) frameData[i] = MAX_W'($urandom_range(0, 16'hFFFE));
        sendFrame(MODE_TAUT, MODE_EQ, 0, -1, '0, 1'b1, 0, "taut");
        consumeResult("taut");

        writeBound(5, 16'd100);
        for (int i = 0; i < NUM_VARS; i++) frameData[i] = '0;
        frameData[5] = 16'd101;
        sendFrame(MODE_LE, MODE_LE, 0, -1, '0, 1'b0, 5, "le");
        consumeResult("le");

        // EQ with gaps; a same-cycle write to index 10 must not affect this frame.
        for (int i = 0; i < NUM_VARS; i++) writeBound(i, 16'h00AA);
        for (int i = 0; i < NUM_VARS; i++) frameData[i] = 16'h00AA;
        sendFrame(MODE_EQ, MODE_EQ, 3, 10, 16'h0055, 1'b1, 0, "eq_gaps");
        consumeResult("eq_gaps");

        // Index 10 now holds 0x55, so this frame fails there; the result must hold under backpressure.
        sendFrame(MODE_EQ, MODE_EQ, 0, -1, '0, 1'b0, 10, "hold");
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 16'h00AA, MODE_EQ, (c % 2) == 0, 1'b0);
            checkOutput("hold_valid", 32'(strm.out_valid), 32'd1);
            checkOutput("hold_sat", 32'(strm.out_sat), 32'd0);
            checkOutput("hold_in_ready", 32'(strm.in_ready), 32'd0);
        end
        strm.in_valid = 1'b0;
        abort = 1'b0;
        consumeResult("hold");
        writeBound(10, 16'h00AA);

        // Abort a failing partial frame at index 70, then a clean NE frame.
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, 16'hFFFF, (i == 0) ? MODE_LE : MODE_LE, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hFFFF, MODE_LE, 1'b1, 1'b0);
        abort = 1'b0;
        for (int i = 0; i < NUM_VARS; i++) frameData[i] = 16'h0001;
        sendFrame(MODE_NE, MODE_EQ, 0, -1, '0, 1'b1, 0, "abort_ne");
        consumeResult("abort_ne");

        // Reset mid-frame at index 40.
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16'h1234, MODE_LE, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h1234, MODE_LE, 1'b0, 1'b0);
        rst = 1'b0;
        strm.in_valid = 1'b0;
        checkOutput("midrst_in_ready", 32'(strm.in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(strm.out_valid), 32'd0);
        checkOutput("midrst_out_sat", 32'(strm.out_sat), 32'd0);
        checkOutput("midrst_viol", 32'(strm.out_viol_idx), 32'd0);
        for (int i = 0; i < NUM_VARS; i++) frameData[i] = 16'hFFFF;
        frameData[3] = 16'h0000;
        sendFrame(MODE_EQ, MODE_EQ, 0, -1, '0, 1'b0, 3, "post_rst");
        consumeResult("post_rst");

        applyStimulus(1'b0, '0, MODE_TAUT, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
